bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the CPU core's instruction-bus and data-bus masters (`ibus_if`, `dbus_if`). It lets both share a single memory bus port. It grants ownership with a registered state machine and multiplexes the owner's address and control signals onto the slave port. It returns slave `ready`/`rd_data` only to the owner, and it recovers from an unresponsive slave with a watchdog timeout. It sits between the core's `ibus_*`/`dbus_*` ports and the memory/peripheral bus.

---
 rtl/bus_arbiter_pkg.sv | 13 +
 rtl/bus_arb_wdt.sv | 32 +++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
// Arbitration state encodings and the default watchdog timeout.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/bus_arb_wdt.sv
// Watchdog for the shared slave port: counts strobe cycles without
// a slave ready and emits a registered one-cycle expire pulse.
module bus_arb_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic as,
  input  logic ready,
  input  logic clr,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt;
  logic        fire;

  assign fire = as & ~ready & ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      expire <= fire;
      if (clr || !as || ready || fire) cnt <= '0;
      else                             cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (ibus/dbus) to one-slave arbiter with watchdog timeout.
// Define BUS_ARB_RR_EN for round-robin; default is fixed dbus priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_as,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              i_get,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rd_data,
  input  logic              d_req,
  input  logic              d_as,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_get,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              s_as,
  output logic              s_rw,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wr_data,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rd_data,
  output logic              bus_err
);

  arb_state_t  state, state_nx;
  logic        d_wins;
  logic        expire;
  logic        clr;
  logic        done;
  logic [DATA_W-1:0] ret_data;

`ifdef BUS_ARB_RR_EN
  logic last_i;

  assign d_wins = last_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_i <= 1'b1;
    end else if (clr && state_nx != ARB_IDLE) begin
      last_i <= (state_nx == ARB_OWN_I);
    end
  end
`else
  assign d_wins = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: begin
        if (d_req && (!i_req || d_wins)) state_nx = ARB_OWN_D;
        else if (i_req)                  state_nx = ARB_OWN_I;
      end
      ARB_OWN_I: begin
        if (!i_req) state_nx = d_req ? ARB_OWN_D : ARB_IDLE;
      end
      ARB_OWN_D: begin
        if (!d_req) state_nx = i_req ? ARB_OWN_I : ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  assign clr = (state_nx != state);

  // A forced completion returns zero unless the slave answered anyway.
  assign done     = s_ready | expire;
  assign ret_data = (expire & ~s_ready) ? '0 : s_rd_data;

  always_comb begin
    i_get     = 1'b0;
    d_get     = 1'b0;
    s_as      = 1'b0;
    s_rw      = 1'b0;
    s_addr    = '0;
    s_wr_data = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_rd_data = '0;
    d_rd_data = '0;
    unique case (state)
      ARB_OWN_I: begin
        i_get     = 1'b1;
        s_as      = i_as;
        s_rw      = i_rw;
        s_addr    = i_addr;
        s_wr_data = i_wr_data;
        i_ready   = done;
        i_rd_data = ret_data;
      end
      ARB_OWN_D: begin
        d_get     = 1'b1;
        s_as      = d_as;
        s_rw      = d_rw;
        s_addr    = d_addr;
        s_wr_data = d_wr_data;
        d_ready   = done;
        d_rd_data = ret_data;
      end
      default: ;
    endcase
  end

  assign bus_err = expire;

  bus_arb_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk   (clk),
    .rst   (rst),
    .as    (s_as),
    .ready (s_ready),
    .clr   (clr),
    .expire(expire)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT = 4).
// Checks follow BUS_ARB_RR_EN when the macro is defined.
module tb_bus_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_as, i_rw;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wr_data;
  logic          i_get, i_ready;
  logic [DW-1:0] i_rd_data;
  logic          d_req, d_as, d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wr_data;
  logic          d_get, d_ready;
  logic [DW-1:0] d_rd_data;
  logic          s_as, s_rw;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wr_data;
  logic          s_ready;
  logic [DW-1:0] s_rd_data;
  logic          bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_as     (i_as),
    .i_rw     (i_rw),
    .i_addr   (i_addr),
    .i_wr_data(i_wr_data),
    .i_get    (i_get),
    .i_ready  (i_ready),
    .i_rd_data(i_rd_data),
    .d_req    (d_req),
    .d_as     (d_as),
    .d_rw     (d_rw),
    .d_addr   (d_addr),
    .d_wr_data(d_wr_data),
    .d_get    (d_get),
    .d_ready  (d_ready),
    .d_rd_data(d_rd_data),
    .s_as     (s_as),
    .s_rw     (s_rw),
    .s_addr   (s_addr),
    .s_wr_data(s_wr_data),
    .s_ready  (s_ready),
    .s_rd_data(s_rd_data),
    .bus_err  (bus_err)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic exp_d;

  initial begin
    rst = 1'b0;
    i_req = 1'b1; i_as = 1'b0; i_rw = 1'b0;
    i_addr = '0; i_wr_data = '0;
    d_req = 1'b1; d_as = 1'b1; d_rw = 1'b1;
    d_addr = 30'h3; d_wr_data = 32'h7;
    s_ready = 1'b1; s_rd_data = 32'h55;

    step(); step();
    check("rst_i_get", i_get, 0);
    check("rst_d_get", d_get, 0);
    check("rst_err", bus_err, 0);
    check("rst_s_as", s_as, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_d_rd", d_rd_data, 0);

    s_ready = 1'b0; d_as = 1'b0;
    rst = 1'b1;
    step();
    check("rel_d_get", d_get, 1);
    check("rel_i_get", i_get, 0);

    i_req = 1'b0; d_req = 1'b0;
    step();
    check("idle_d_get", d_get, 0);

    // Instruction read alone
    i_req = 1'b1;
    step();
    check("ird_get", i_get, 1);
    i_as = 1'b1; i_rw = 1'b1; i_addr = 30'h100;
    settle();
    check("ird_s_as", s_as, 1);
    check("ird_s_rw", s_rw, 1);
    check("ird_s_addr", s_addr, 30'h100);
    step(); step();
    check("ird_wait", i_ready, 0);
    s_ready = 1'b1; s_rd_data = 32'hDEADBEEF;
    settle();
    check("ird_ready", i_ready, 1);
    check("ird_data", i_rd_data, 32'hDEADBEEF);
    check("ird_d_ready", d_ready, 0);
    check("ird_d_data", d_rd_data, 0);
    check("ird_err", bus_err, 0);
    step();
    s_ready = 1'b0; i_as = 1'b0;
    settle();
    check("ird_ready_off", i_ready, 0);
    i_req = 1'b0;
    step();
    check("ird_rel", i_get, 0);

    // Contention: last owner was I, so both builds grant D
    i_req = 1'b1; d_req = 1'b1;
    step();
    check("cont_d_get", d_get, 1);
    check("cont_i_get", i_get, 0);

    // Non-owner strobe is ignored
    i_as = 1'b1; i_addr = 30'h200;
    d_as = 1'b0; d_addr = 30'h55;
    settle();
    check("nown_s_as", s_as, 0);
    check("nown_s_addr", s_addr, 30'h55);
    s_ready = 1'b1; s_rd_data = 32'h1111;
    settle();
    check("nown_i_ready", i_ready, 0);
    check("nown_d_ready", d_ready, 1);
    s_ready = 1'b0;
    d_as = 1'b1; d_rw = 1'b0; d_wr_data = 32'hCAFE;
    settle();
    check("dwr_s_as", s_as, 1);
    check("dwr_s_rw", s_rw, 0);
    check("dwr_s_wd", s_wr_data, 32'hCAFE);
    step();
    d_as = 1'b0; i_as = 1'b0;

    d_req = 1'b0;
    step();
    check("hand_i_get", i_get, 1);
    check("hand_d_get", d_get, 0);

    // Repeated simultaneous requests from IDLE
    for (int k = 0; k < 4; k++) begin
      i_req = 1'b0; d_req = 1'b0;
      step();
      i_req = 1'b1; d_req = 1'b1;
      step();
`ifdef BUS_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check($sformatf("arb%0d_d", k), d_get, exp_d);
      check($sformatf("arb%0d_i", k), i_get, !exp_d);
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Timeout with no slave response
    i_req = 1'b1;
    step();
    i_as = 1'b1; s_rd_data = 32'h1234;
    step(); step(); step();
    check("to_c4_ready", i_ready, 0);
    check("to_c4_err", bus_err, 0);
    step();
    check("to_ready", i_ready, 1);
    check("to_data", i_rd_data, 0);
    check("to_err", bus_err, 1);
    check("to_d_ready", d_ready, 0);
    step();
    check("to_err_off", bus_err, 0);
    check("to_ready_off", i_ready, 0);
    i_as = 1'b0;
    step();

    // Slave answers in the last counted cycle
    i_as = 1'b1;
    step(); step(); step();
    s_ready = 1'b1; s_rd_data = 32'hA5A5;
    settle();
    check("pre_ready", i_ready, 1);
    check("pre_data", i_rd_data, 32'hA5A5);
    step();
    s_ready = 1'b0;
    settle();
    check("pre_err", bus_err, 0);
    check("pre_ready_off", i_ready, 0);
    i_as = 1'b0;
    step();

    // Requester leaves mid-transfer; late ready is dropped
    i_as = 1'b1;
    step();
    i_req = 1'b0;
    step();
    s_ready = 1'b1; s_rd_data = 32'hBEEF;
    settle();
    check("late_get", i_get, 0);
    check("late_ready", i_ready, 0);
    check("late_data", i_rd_data, 0);
    s_ready = 1'b0; i_as = 1'b0;

    // Reset mid-transfer
    d_req = 1'b1;
    step();
    d_as = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    settle();
    check("mrst_get", d_get, 0);
    check("mrst_ready", d_ready, 0);
    step();
    check("mrst_err", bus_err, 0);
    check("mrst_s_as", s_as, 0);
    d_req = 1'b0; d_as = 1'b0;
    rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
